// File: rtl/riscv_lsu_split.sv
// Load/store unit between the core data port and a word-wide memory.
// Word-crossing accesses take two aligned beats; strict mode rejects misaligned accesses.
module riscv_lsu_split #(
    parameter bit          MISALIGN_SPLIT = 1'b1,
    parameter int unsigned TIMEOUT_CYC    = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    typedef enum logic {BEAT0 = 1'b0, BEAT1 = 1'b1} state_t;

    state_t      state_r;
    logic [31:0] lo_r;
    logic [31:0] tmo_cnt_r;

    logic [1:0]  off_s;
    logic [2:0]  nbytes_s;
    logic [3:0]  mask_s;
    logic [7:0]  be_span_s;
    logic        misaligned_s;
    logic        crossing_s;
    logic        strict_err_s;
    logic        tmo_err_s;
    logic        err_s;
    logic        mem_req_s;
    logic        beat_done_s;
    logic        final_s;
    logic        complete_s;
    logic [31:0] word_addr_s;
    logic [31:0] wd_rot_s;
    logic [63:0] pair_s;
    logic [63:0] pair_shift_s;
    logic [31:0] raw_s;
    logic [31:0] ext_s;

    assign off_s = core_addr_i[1:0];

    // Access width and byte mask from the size code (unknown codes act as word)
    always_comb begin
        nbytes_s = 3'd4;
        mask_s   = 4'b1111;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                nbytes_s = 3'd1;
                mask_s   = 4'b0001;
            end
            LDST_H, LDST_HU: begin
                nbytes_s = 3'd2;
                mask_s   = 4'b0011;
            end
            default: begin
                nbytes_s = 3'd4;
                mask_s   = 4'b1111;
            end
        endcase
    end

    assign misaligned_s = ((nbytes_s == 3'd2) && off_s[0]) || ((nbytes_s == 3'd4) && (off_s != 2'd0));
    assign crossing_s   = (({1'b0, off_s} + nbytes_s) > 3'd4);
    assign be_span_s    = {4'b0000, mask_s} << off_s;

    assign strict_err_s = (MISALIGN_SPLIT == 1'b0) && misaligned_s && (state_r == BEAT0)
                          && core_req_i && !rst_i;
    assign mem_req_s    = !rst_i && ((state_r == BEAT1) || (core_req_i && !strict_err_s));
    assign tmo_err_s    = (TIMEOUT_CYC != 0) && mem_req_s && !mem_ready_i && (tmo_cnt_r == TMO_LAST);
    assign err_s        = strict_err_s || tmo_err_s;
    assign beat_done_s  = mem_req_s && mem_ready_i;
    assign final_s      = beat_done_s && ((state_r == BEAT1) || !crossing_s);
    assign complete_s   = final_s || err_s;

    assign word_addr_s  = {core_addr_i[31:2], 2'b00};

    // Store data rotated so each byte lands on its lane in either beat
    always_comb begin
        wd_rot_s = core_wd_i;
        case (off_s)
            2'd0:    wd_rot_s = core_wd_i;
            2'd1:    wd_rot_s = {core_wd_i[23:0], core_wd_i[31:24]};
            2'd2:    wd_rot_s = {core_wd_i[15:0], core_wd_i[31:16]};
            2'd3:    wd_rot_s = {core_wd_i[7:0],  core_wd_i[31:8]};
            default: wd_rot_s = core_wd_i;
        endcase
    end

    assign pair_s       = (state_r == BEAT1) ? {mem_rd_i, lo_r} : {32'd0, mem_rd_i};
    assign pair_shift_s = pair_s >> {off_s, 3'b000};
    assign raw_s        = pair_shift_s[31:0];

    // Sign/zero extension of the assembled load data
    always_comb begin
        ext_s = raw_s;
        case (core_size_i)
            LDST_B:  ext_s = {{24{raw_s[7]}}, raw_s[7:0]};
            LDST_H:  ext_s = {{16{raw_s[15]}}, raw_s[15:0]};
            LDST_BU: ext_s = {24'd0, raw_s[7:0]};
            LDST_HU: ext_s = {16'd0, raw_s[15:0]};
            LDST_W:  ext_s = raw_s;
            default: ext_s = raw_s;
        endcase
    end

    assign mem_req_o    = mem_req_s;
    assign mem_we_o     = core_we_i;
    assign mem_be_o     = (state_r == BEAT1) ? be_span_s[7:4] : be_span_s[3:0];
    assign mem_addr_o   = (state_r == BEAT1) ? (word_addr_s + 32'd4) : word_addr_s;
    assign mem_wd_o     = wd_rot_s;
    assign core_stall_o = !rst_i && core_req_i && !complete_s;
    assign core_err_o   = !rst_i && err_s;
    assign core_rd_o    = rst_i ? 32'd0 : ext_s;

    // Beat sequencing, beat-0 read capture and per-beat timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= BEAT0;
            lo_r      <= 32'd0;
            tmo_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                BEAT0: begin
                    if (err_s) begin
                        tmo_cnt_r <= 32'd0;
                    end else if (beat_done_s) begin
                        tmo_cnt_r <= 32'd0;
                        if (crossing_s) begin
                            lo_r    <= mem_rd_i;
                            state_r <= BEAT1;
                        end
                    end else if (mem_req_s) begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    end else begin
                        tmo_cnt_r <= 32'd0;
                    end
                end
                BEAT1: begin
                    if (err_s || beat_done_s) begin
                        state_r   <= BEAT0;
                        tmo_cnt_r <= 32'd0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r   <= BEAT0;
                    tmo_cnt_r <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu_split.sv
// Directed scoreboard bench for riscv_lsu_split: split/timeout instance plus a strict-mode instance.
module tb_riscv_lsu_split;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o, core_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    logic [31:0] s_core_rd_o;
    logic        s_core_stall_o, s_core_err_o;
    logic        s_mem_req_o, s_mem_we_o;
    logic [3:0]  s_mem_be_o;
    logic [31:0] s_mem_addr_o, s_mem_wd_o;

    typedef struct packed { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wd; } beat_t;
    typedef struct packed { logic [31:0] rd; logic err; logic chk_rd; } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];
    int compared = 0;
    int mismatched = 0;

    riscv_lsu_split #(.MISALIGN_SPLIT(1'b1), .TIMEOUT_CYC(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_err_o(core_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i));

    riscv_lsu_split #(.MISALIGN_SPLIT(1'b0), .TIMEOUT_CYC(0)) dut_strict (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(s_core_rd_o), .core_stall_o(s_core_stall_o), .core_err_o(s_core_err_o),
        .mem_req_o(s_mem_req_o), .mem_we_o(s_mem_we_o), .mem_be_o(s_mem_be_o),
        .mem_addr_o(s_mem_addr_o), .mem_wd_o(s_mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] be, input logic we, input logic [31:0] wd);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wd = wd;
        beat_q.push_back(b);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic err, input logic chk_rd);
        resp_t r;
        r.rd = rd; r.err = err; r.chk_rd = chk_rd;
        resp_q.push_back(r);
    endtask

    // One sampling point: drive memory side, let logic settle, score beats and completions
    task automatic tick(input logic rdy, input logic [31:0] rd, output bit done);
        beat_t b;
        resp_t r;
        mem_ready_i = rdy;
        mem_rd_i    = rd;
        #2;
        done = 1'b0;
        if (mem_req_o && mem_ready_i) begin
            chk("beat_pending", 32'(beat_q.size() > 0), 32'd1);
            if (beat_q.size() > 0) begin
                b = beat_q.pop_front();
                chk("beat_addr", mem_addr_o, b.addr);
                chk("beat_be", 32'(mem_be_o), 32'(b.be));
                chk("beat_we", 32'(mem_we_o), 32'(b.we));
                if (b.we) chk("beat_wd", mem_wd_o, b.wd);
            end
        end
        if (core_req_i && !core_stall_o) begin
            done = 1'b1;
            chk("resp_pending", 32'(resp_q.size() > 0), 32'd1);
            if (resp_q.size() > 0) begin
                r = resp_q.pop_front();
                chk("resp_err", 32'(core_err_o), 32'(r.err));
                if (r.chk_rd) chk("resp_rd", core_rd_o, r.rd);
            end
        end
    endtask

    // strict_mode: 0 = no strict check, 1 = expect reject, 2 = expect normal issue
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1, input int wait0, input int wait1,
                          input int exp_stalls, input int strict_mode);
        int  w;
        int  beats;
        int  stalls;
        bit  done;
        w = wait0; beats = 0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr; core_wd_i = wd;
            end
            tick((w == 0), (beats == 0) ? rd0 : rd1, done);
            if (c == 0 && strict_mode == 1) begin
                chk("strict_req", 32'(s_mem_req_o), 32'd0);
                chk("strict_err", 32'(s_core_err_o), 32'd1);
                chk("strict_stall", 32'(s_core_stall_o), 32'd0);
            end else if (c == 0 && strict_mode == 2) begin
                chk("strict_issue", 32'(s_mem_req_o), 32'd1);
                chk("strict_noerr", 32'(s_core_err_o), 32'd0);
                chk("strict_addr", s_mem_addr_o, {addr[31:2], 2'b00});
            end
            if (mem_req_o && mem_ready_i) begin
                beats++;
                w = wait1;
            end else if (w > 0) begin
                w--;
            end
            if (!done && core_stall_o) stalls++;
        end
        chk("access_done", 32'(done), 32'd1);
        if (done) chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h1000; core_wd_i = 32'd0; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
        @(negedge clk_i); #2;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_err", 32'(core_err_o), 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i); #2;
        chk("idle_mem_req", 32'(mem_req_o), 32'd0);
        chk("idle_stall", 32'(core_stall_o), 32'd0);

        // aligned LW, zero-latency
        exp_beat(32'h1000, 4'b1111, 1'b0, 32'd0); exp_resp(32'hDEADBEEF, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'h1000, 32'd0, 32'hDEADBEEF, 32'd0, 0, 0, 0, 2);
        // word-crossing LW
        exp_beat(32'h1000, 4'b1100, 1'b0, 32'd0); exp_beat(32'h1004, 4'b0011, 1'b0, 32'd0);
        exp_resp(32'h3344AABB, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'h1002, 32'd0, 32'hAABBCCDD, 32'h11223344, 0, 0, 1, 1);
        // word-crossing SH
        exp_beat(32'h1000, 4'b1000, 1'b1, 32'hEF0000BE); exp_beat(32'h1004, 4'b0001, 1'b1, 32'hEF0000BE);
        exp_resp(32'd0, 1'b0, 1'b0);
        access(1'b1, 3'd1, 32'h1003, 32'h0000BEEF, 32'd0, 32'd0, 0, 0, 1, 1);
        // misaligned non-crossing LH / LHU
        exp_beat(32'h2000, 4'b0110, 1'b0, 32'd0); exp_resp(32'hFFFFF000, 1'b0, 1'b1);
        access(1'b0, 3'd1, 32'h2001, 32'd0, 32'h12F00034, 32'd0, 0, 0, 0, 1);
        exp_beat(32'h2000, 4'b0110, 1'b0, 32'd0); exp_resp(32'h0000F000, 1'b0, 1'b1);
        access(1'b0, 3'd5, 32'h2001, 32'd0, 32'h12F00034, 32'd0, 0, 0, 0, 1);
        // address wrap on the second beat
        exp_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'd0); exp_beat(32'h00000000, 4'b0011, 1'b0, 32'd0);
        exp_resp(32'hBEEFCAFE, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0, 1, 0);
        // byte loads/stores and word store
        exp_beat(32'h3000, 4'b1000, 1'b0, 32'd0); exp_resp(32'hFFFFFF80, 1'b0, 1'b1);
        access(1'b0, 3'd0, 32'h3003, 32'd0, 32'h80123456, 32'd0, 0, 0, 0, 2);
        exp_beat(32'h3000, 4'b0100, 1'b0, 32'd0); exp_resp(32'h000000A5, 1'b0, 1'b1);
        access(1'b0, 3'd4, 32'h3002, 32'd0, 32'h00A50000, 32'd0, 0, 0, 0, 2);
        exp_beat(32'h3000, 4'b0010, 1'b1, 32'h0000AB00); exp_resp(32'd0, 1'b0, 1'b0);
        access(1'b1, 3'd0, 32'h3001, 32'h000000AB, 32'd0, 32'd0, 0, 0, 0, 2);
        exp_beat(32'h3000, 4'b1111, 1'b1, 32'h12345678); exp_resp(32'd0, 1'b0, 1'b0);
        access(1'b1, 3'd2, 32'h3000, 32'h12345678, 32'd0, 32'd0, 0, 0, 0, 2);
        // reserved size codes behave as word
        exp_beat(32'h5000, 4'b1111, 1'b0, 32'd0); exp_resp(32'h89ABCDEF, 1'b0, 1'b1);
        access(1'b0, 3'd7, 32'h5000, 32'd0, 32'h89ABCDEF, 32'd0, 0, 0, 0, 2);
        exp_beat(32'h5000, 4'b1110, 1'b0, 32'd0); exp_beat(32'h5004, 4'b0001, 1'b0, 32'd0);
        exp_resp(32'h55443322, 1'b0, 1'b1);
        access(1'b0, 3'd3, 32'h5001, 32'd0, 32'h44332211, 32'h88776655, 0, 0, 1, 1);
        // timeout: error in the 4th waiting cycle; 3 waits then ready is fine
        exp_resp(32'd0, 1'b1, 1'b0);
        access(1'b0, 3'd2, 32'h6000, 32'd0, 32'd0, 32'd0, 100, 100, 3, 0);
        exp_beat(32'h6000, 4'b1111, 1'b0, 32'd0); exp_resp(32'h0F0F0F0F, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'h6000, 32'd0, 32'h0F0F0F0F, 32'd0, 3, 3, 3, 0);
        exp_beat(32'h6000, 4'b1110, 1'b0, 32'd0); exp_beat(32'h6004, 4'b0001, 1'b0, 32'd0);
        exp_resp(32'h44332211, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'h6001, 32'd0, 32'h33221100, 32'h77665544, 3, 3, 7, 0);
        // timeout on a store's second beat
        exp_beat(32'h7000, 4'b1100, 1'b1, 32'hCCDDAABB); exp_resp(32'd0, 1'b1, 1'b0);
        access(1'b1, 3'd2, 32'h7002, 32'hAABBCCDD, 32'd0, 32'd0, 0, 100, 4, 0);

        // reset while waiting in the second beat
        exp_beat(32'h1000, 4'b1100, 1'b0, 32'd0);
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h1002;
        tick(1'b1, 32'hAABBCCDD, done);
        chk("split_pending", 32'(core_stall_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1; mem_ready_i = 1'b0; #2;
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_stall", 32'(core_stall_o), 32'd0);
        chk("midrst_rd", core_rd_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_beat(32'h4000, 4'b1111, 1'b0, 32'd0); exp_resp(32'h01020304, 1'b0, 1'b1);
        access(1'b0, 3'd2, 32'h4000, 32'd0, 32'h01020304, 32'd0, 0, 0, 0, 2);

        @(negedge clk_i);
        core_req_i = 1'b0;
        chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/riscv_lsu_split.md
Name: riscv_lsu_split

Overview:
Load/store unit between the core's data-access port and the word-wide data memory, and the successor to the current single-beat LSU. It adds hardware handling of misaligned accesses: a word-crossing access is split into two aligned memory beats, or, in strict mode, rejected with an error. It also adds an optional memory-response timeout. Core-side size encoding and sign/zero-extension are unchanged: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.

Parameters:
MISALIGN_SPLIT, 1, 1: misaligned accesses are executed (split when word-crossing); 0: any misaligned access returns core_err_o with no memory traffic.
TIMEOUT_CYC, 0, cycles to wait per beat for mem_ready_i before an error response; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
core_req_i  in  1  access request; held with all core_* inputs stable while core_stall_o=1
core_we_i  in  1  1=store
core_size_i  in  3  LDST_* encoding; codes 3, 6 and 7 treated as LDST_W
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, right-aligned
core_rd_o  out  32  extended load data; valid in the completion cycle
core_stall_o  out  1  1 while the access is not complete
core_err_o  out  1  1-cycle pulse, in the completion cycle, for misaligned (strict mode) or timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word-aligned address (bits [1:0] always 0)
mem_wd_o  out  32  write data
mem_rd_i  in  32  read data; valid when mem_ready_i=1
mem_ready_i  in  1  beat completes in any cycle where mem_req_o=1 and mem_ready_i=1

Behaviour:
- Definitions: off=core_addr_i[1:0]; nbytes=1/2/4 for B/H/W. Misaligned: H with off[0]=1, or W with off!=0. Crossing: off+nbytes>4 (H at off 3; W at off 1, 2 or 3).
- FSM states: BEAT0 and BEAT1. Reset state is BEAT0; the timeout counter and lo_q (32-bit beat-0 read capture) reset to 0.
- While rst_i=1: mem_req_o=0, core_stall_o=0, core_err_o=0, core_rd_o=0.
- BEAT0 with core_req_i=1 (zero-latency issue): mem_req_o=1 in the same cycle. mem_addr_o={addr[31:2],2'b00}, mem_we_o=core_we_i, mem_be_o=(mask(nbytes)<<off)[3:0], where mask = 0001/0011/1111.
- Store data, both beats: mem_wd_o = core_wd_i rotated left by 8*off bits. Example: SH with off=3, wd=0x0000BEEF gives 0xEF0000BE.
- BEAT0, non-crossing: on mem_ready_i the access completes that cycle (core_stall_o=0) and core_rd_o is produced from mem_rd_i.
- BEAT0, crossing, on mem_ready_i: lo_q<=mem_rd_i, go to BEAT1; core_stall_o stays 1.
- BEAT1: mem_req_o=1, mem_addr_o=word address+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). mem_be_o = (mask(nbytes)<<off)[7:4]. On mem_ready_i: complete, return to BEAT0.
- Load assembly: raw = ({beat1 rd, lo_q} >> 8*off)[31:0] for split accesses, or (mem_rd_i >> 8*off) for single beats. Then sign-extend (B, H) or zero-extend (BU, HU) from the low nbytes; W passes raw unchanged.
- core_stall_o = core_req_i && !complete, where complete = final-beat mem_ready_i, or an error this cycle. core_rd_o is don't-care for stores and on error.
- Strict mode (MISALIGN_SPLIT=0), misaligned request in BEAT0: mem_req_o=0; core_err_o=1 and core_stall_o=0 in the same cycle.
- Timeout (TIMEOUT_CYC>0): counter increments each cycle mem_req_o=1 && !mem_ready_i, and clears on beat completion. When it reaches TIMEOUT_CYC-1 with no ready: core_err_o=1, core_stall_o=0, go to BEAT0, clear the counter. A timeout on a store's BEAT1 leaves beat 0 written; no rollback.
- core_req_i=0 in BEAT0: mem_req_o=0, stall=0, counter holds 0.
- A back-to-back request in the cycle after completion issues immediately; no bubble.
- Reset mid-split (in BEAT1): state returns to BEAT0 and lo_q is cleared; the pending beat is abandoned.

Test Plan:
- LW addr 0x1000, mem_ready_i=1 in the request cycle, mem_rd=0xDEADBEEF -> mem_be=1111, core_rd=0xDEADBEEF, core_stall_o=0 in the same cycle.
- LW addr 0x1002, ready every beat, rd0=0xAABBCCDD, rd1=0x11223344 -> beat0 addr 0x1000 be 1100; beat1 addr 0x1004 be 0011; core_rd=0x3344AABB; stall high for exactly 1 cycle.
- SH addr 0x1003, wd=0x0000BEEF -> beat0 addr 0x1000 be 1000 wd 0xEF0000BE; beat1 addr 0x1004 be 0001 wd 0xEF0000BE.
- LH addr 0x2001, mem_rd=0x12F00034: MISALIGN_SPLIT=1 -> single beat, be 0110, core_rd=0xFFFFF000 (LHU gives 0x0000F000). MISALIGN_SPLIT=0 -> no mem_req, core_err_o=1 in the same cycle.
- LW addr 0xFFFFFFFE -> beat0 addr 0xFFFFFFFC be 1100, beat1 addr 0x00000000 be 0011.
- TIMEOUT_CYC=4, mem_ready_i held 0 -> core_err_o=1 and stall low in the 4th request cycle. Separately, rst_i pulsed while in BEAT1 -> next cycle is BEAT0 and a fresh request issues beat 0.
